// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access engine.
//   state_t   : access FSM encoding (IDLE, REQ, WAIT_R, DONE)
//   F3_*      : Funct3 load/store size codes
//   size_t    : decoded access width, produced by size_of()
package mem_access_unit_pkg;

    localparam int NUM_LANES = 4;  // byte lanes on the 32-bit data bus

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Sign bit of Funct3 does not affect the bus access width; anything that
    // is not a byte or halfword code is treated as a full word.
    function automatic size_t size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// req/gnt/rvalid data-bus between the access engine (master) and memory (slave).
//   req/we/addr/wstrb/wdata : master -> slave request
//   gnt                     : slave accepts the request this cycle
//   rvalid/rdata            : slave read-data return
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wstrb, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wstrb, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit_store_lane_align.sv
// Combinational byte-lane steering for one MEM-stage access.
//   funct3, addr_lo        : access size and byte offset within the word
//   store_data             : rs2 value
//   mem_read, mem_write    : access type (never both)
//   wstrb                  : byte enables, zero unless writing
//   wdata                  : store data replicated across every lane of its size
//   misalign               : access present and not naturally aligned
module store_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);

    size_t                          sz;
    logic [3:0]                     strb;
    logic [NUM_LANES-1:0][7:0]      lanes;
    logic                           bad_align;

    assign sz = size_of(funct3);

    always_comb begin
        strb      = 4'b1111;
        bad_align = 1'b0;
        case (sz)
            SZ_B: strb = 4'b0001 << addr_lo;
            SZ_H: begin
                strb      = 4'b0011 << addr_lo;
                bad_align = addr_lo[0];
            end
            default: bad_align = |addr_lo;
        endcase
    end

    // Replicate so the slave finds the data on whichever lanes wstrb enables.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        always_comb begin
            case (sz)
                SZ_B:    lanes[l] = store_data[7:0];
                SZ_H:    lanes[l] = store_data[(l % 2)*8 +: 8];
                default: lanes[l] = store_data[l*8 +: 8];
            endcase
        end
    end

    assign wdata    = lanes;
    assign wstrb    = mem_write ? strb : 4'b0000;
    assign misalign = (mem_read | mem_write) & bad_align;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine.
//   clk, rst_n                    : clock, async active-low reset
//   MemReadM/MemWriteM/Funct3M    : MEM-stage load/store control
//   AluOutM, StoreDataM           : byte address, store value
//   bus                           : req/gnt/rvalid data bus (master side)
//   RamDataM                      : raw 32-bit load word (held until next load)
//   StallMem                      : hold the pipeline while an access is in flight
//   MisalignM                     : misaligned access seen in IDLE (no bus cycle)
//   BusErrM                       : high during DONE after a timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [2:0]                Funct3M,
    input  logic [31:0]               AluOutM,
    input  logic [31:0]               StoreDataM,
    mem_access_unit_if.master         bus,
    output logic [31:0]               RamDataM,
    output logic                      StallMem,
    output logic                      MisalignM,
    output logic                      BusErrM
);

    // Wide enough to hold TIMEOUT_CYCLES itself: a grant on the last REQ cycle
    // carries the count one past the limit into WAIT_R.
    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic [3:0]      strb;
    logic [31:0]     wdata;
    logic            misalign;
    logic            access;
    logic            start;
    logic            tmo_hit;

    store_lane_align u_align (
        .funct3     (Funct3M),
        .addr_lo    (AluOutM[1:0]),
        .store_data (StoreDataM),
        .mem_read   (MemReadM),
        .mem_write  (MemWriteM),
        .wstrb      (strb),
        .wdata      (wdata),
        .misalign   (misalign)
    );

    assign access  = MemReadM | MemWriteM;
    assign start   = (state == IDLE) & access & ~misalign;
    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    assign MisalignM = rst_n & (state == IDLE) & misalign;
    assign StallMem  = rst_n & (start | (state == REQ) | (state == WAIT_R));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wstrb <= '0;
            bus.wdata <= '0;
            RamDataM  <= '0;
            tmo_cnt   <= '0;
            BusErrM   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    BusErrM <= 1'b0;
                    if (start) begin
                        bus.req   <= 1'b1;
                        bus.we    <= MemWriteM;
                        bus.addr  <= {AluOutM[31:2], 2'b00};
                        bus.wstrb <= strb;
                        bus.wdata <= wdata;
                        tmo_cnt   <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.gnt) begin
                        bus.req <= 1'b0;
                        tmo_cnt <= tmo_cnt + 1'b1;
                        state   <= bus.we ? DONE : WAIT_R;
                    end else if (tmo_hit) begin
                        bus.req <= 1'b0;
                        if (!bus.we) RamDataM <= ERR_DATA;
                        BusErrM <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus.rvalid) begin
                        RamDataM <= bus.rdata;
                        state    <= DONE;
                    end else if (tmo_hit) begin
                        RamDataM <= ERR_DATA;
                        BusErrM  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    BusErrM <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
